// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline hazard inputs and stall/flush/status outputs.
interface hazard_stall_unit_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] R2_1, R3_1, DestR_2;
    logic             UseR2_1, UseR3_1, MemRead_2, WrEn_2, BrTaken_2, MemReq_3, MemReady_3;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr;
    logic [CNT_W-1:0] StallCnt;
    modport master (
        output R2_1, R3_1, DestR_2, UseR2_1, UseR3_1, MemRead_2, WrEn_2, BrTaken_2, MemReq_3, MemReady_3,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr, StallCnt
    );
    modport slave (
        input  R2_1, R3_1, DestR_2, UseR2_1, UseR3_1, MemRead_2, WrEn_2, BrTaken_2, MemReq_3, MemReady_3,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, MemErr, StallCnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use, branch-flush and memory-wait stall control with timeout error.
module hazard_stall_unit #(
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_unit_if.slave hz_io
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {RUN, MWAIT, FLUSH} state_t;
    state_t           state_q, state_d;
    logic             pend_q, pend_d, err_q, err_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REG_W-1:0] dest;
    logic             mwait, lu, stall_all, flush_br, stall_lu, at_max;
    assign dest   = hz_io.DestR_2;
    assign mwait  = hz_io.MemReq_3 & ~hz_io.MemReady_3;
    assign lu     = hz_io.MemRead_2 & hz_io.WrEn_2 &
                    ((hz_io.UseR2_1 & (hz_io.R2_1 == dest)) | (hz_io.UseR3_1 & (hz_io.R3_1 == dest)));
    assign at_max = wcnt_q == WC_W'(TIMEOUT);
    always_comb begin
        stall_all = 1'b0;
        flush_br  = 1'b0;
        stall_lu  = 1'b0;
        state_d   = state_q;
        pend_d    = pend_q;
        wcnt_d    = wcnt_q;
        err_d     = err_q;
        if (state_q == MWAIT) begin
            stall_all = ~hz_io.MemReady_3;
            flush_br  = hz_io.MemReady_3 & pend_q;
            state_d   = hz_io.MemReady_3 ? (pend_q ? FLUSH : RUN) : MWAIT;
            pend_d    = hz_io.MemReady_3 ? 1'b0 : pend_q | hz_io.BrTaken_2;
            wcnt_d    = hz_io.MemReady_3 ? '0 : (at_max ? wcnt_q : wcnt_q + 1'b1);
            err_d     = err_q | (~hz_io.MemReady_3 & at_max);
        end else begin
            // FLUSH only reacts to a new memory wait; branches and load-use wait for RUN
            stall_all = mwait;
            flush_br  = ~mwait & (state_q == RUN) & hz_io.BrTaken_2;
            stall_lu  = ~mwait & (state_q == RUN) & ~hz_io.BrTaken_2 & lu;
            state_d   = mwait ? MWAIT : (flush_br ? FLUSH : RUN);
            pend_d    = mwait ? hz_io.BrTaken_2 : pend_q;
            wcnt_d    = mwait ? WC_W'(1) : wcnt_q;
        end
        if (rst) begin
            stall_all = 1'b0;
            flush_br  = 1'b0;
            stall_lu  = 1'b0;
        end
        cnt_d = ((stall_all | stall_lu) & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    assign hz_io.StallF   = stall_all | stall_lu;
    assign hz_io.StallD   = stall_all | stall_lu;
    assign hz_io.StallE   = stall_all;
    assign hz_io.StallM   = stall_all;
    assign hz_io.FlushD   = flush_br;
    assign hz_io.FlushE   = flush_br | stall_lu;
    assign hz_io.MemErr   = err_q;
    assign hz_io.StallCnt = cnt_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed scenario tests for hazard_stall_unit.
module tb_hazard_stall_unit;
    logic clk = 1'b0;
    logic rst;
    int   errs = 0, checks = 0;
    int   exp_cnt = 0;
    hazard_stall_unit_if #(.REG_W(4), .CNT_W(16)) hz ();
    hazard_stall_unit #(.REG_W(4), .TIMEOUT(15), .CNT_W(16)) dut (.clk(clk), .rst(rst), .hz_io(hz.slave));
    always #5 clk = ~clk;
    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    logic [5:0] outs;
    assign outs = {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        hz.R2_1 = 0; hz.R3_1 = 0; hz.DestR_2 = 0;
        hz.UseR2_1 = 0; hz.UseR3_1 = 0; hz.MemRead_2 = 0; hz.WrEn_2 = 0;
        hz.BrTaken_2 = 0; hz.MemReq_3 = 0; hz.MemReady_3 = 0;
    endtask

    task automatic set_lu();
        hz.MemRead_2 = 1; hz.WrEn_2 = 1; hz.DestR_2 = 5; hz.R3_1 = 5; hz.UseR3_1 = 1;
        hz.R2_1 = 2; hz.UseR2_1 = 1;
    endtask

    task automatic test_reset();
        clear();
        rst = 1;
        hz.MemReq_3 = 1; hz.BrTaken_2 = 1; set_lu();
        cyc();
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL reset_outs got=%b exp=%b", outs, 6'b0); end
        checks++;
        if (hz.StallCnt !== 16'd0 || hz.MemErr !== 1'b0) begin
            errs++; $display("FAIL reset_regs got cnt=%0d err=%b exp cnt=0 err=0", hz.StallCnt, hz.MemErr);
        end
        rst = 0;
        clear();
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL idle_outs got=%b exp=%b", outs, 6'b0); end
        cyc();
    endtask

    task automatic test_load_use();
        set_lu();
        #1;
        checks++;
        if (outs !== 6'b110001) begin errs++; $display("FAIL lu_r3 got=%b exp=%b", outs, 6'b110001); end
        cyc();
        exp_cnt++;
        checks++;
        if (hz.StallCnt !== 16'(exp_cnt)) begin errs++; $display("FAIL lu_cnt got=%0d exp=%0d", hz.StallCnt, exp_cnt); end
        hz.MemRead_2 = 0;
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL lu_clear got=%b exp=%b", outs, 6'b0); end
        cyc();
        clear();
        hz.MemRead_2 = 1; hz.WrEn_2 = 1; hz.DestR_2 = 7; hz.R2_1 = 7; hz.UseR2_1 = 1;
        #1;
        checks++;
        if (outs !== 6'b110001) begin errs++; $display("FAIL lu_r2 got=%b exp=%b", outs, 6'b110001); end
        cyc();
        exp_cnt++;
        hz.UseR2_1 = 0;
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL lu_unused got=%b exp=%b", outs, 6'b0); end
        hz.UseR2_1 = 1; hz.WrEn_2 = 0;
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL lu_nowr got=%b exp=%b", outs, 6'b0); end
        cyc();
        clear();
    endtask

    task automatic test_mem_wait();
        hz.MemReq_3 = 1; hz.MemReady_3 = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111100) begin errs++; $display("FAIL mw_stall%0d got=%b exp=%b", i, outs, 6'b111100); end
            cyc();
            exp_cnt++;
        end
        hz.MemReady_3 = 1;
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL mw_ready got=%b exp=%b", outs, 6'b0); end
        cyc();
        clear();
        checks++;
        if (hz.StallCnt !== 16'(exp_cnt) || hz.MemErr !== 1'b0) begin
            errs++; $display("FAIL mw_regs got cnt=%0d err=%b exp cnt=%0d err=0", hz.StallCnt, hz.MemErr, exp_cnt);
        end
    endtask

    task automatic test_branch_wait();
        hz.MemReq_3 = 1; hz.MemReady_3 = 0; hz.BrTaken_2 = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111100) begin errs++; $display("FAIL bw_stall%0d got=%b exp=%b", i, outs, 6'b111100); end
            cyc();
            exp_cnt++;
        end
        hz.MemReady_3 = 1;
        #1;
        checks++;
        if (outs !== 6'b000011) begin errs++; $display("FAIL bw_flush got=%b exp=%b", outs, 6'b000011); end
        cyc();
        clear();
        set_lu();
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL bw_flushstate got=%b exp=%b", outs, 6'b0); end
        cyc();
        #1;
        checks++;
        if (outs !== 6'b110001) begin errs++; $display("FAIL bw_run got=%b exp=%b", outs, 6'b110001); end
        cyc();
        exp_cnt++;
        clear();
        checks++;
        if (hz.StallCnt !== 16'(exp_cnt)) begin errs++; $display("FAIL bw_cnt got=%0d exp=%0d", hz.StallCnt, exp_cnt); end
    endtask

    task automatic test_branch_lu();
        set_lu();
        hz.BrTaken_2 = 1;
        #1;
        checks++;
        if (outs !== 6'b000011) begin errs++; $display("FAIL blu_flush got=%b exp=%b", outs, 6'b000011); end
        cyc();
        clear();
        hz.MemReq_3 = 1; hz.MemReady_3 = 0;
        #1;
        checks++;
        if (outs !== 6'b111100) begin errs++; $display("FAIL blu_flushwait got=%b exp=%b", outs, 6'b111100); end
        cyc();
        exp_cnt++;
        hz.MemReady_3 = 1;
        cyc();
        clear();
    endtask

    task automatic test_reset_mwait();
        hz.MemReq_3 = 1; hz.MemReady_3 = 0; hz.BrTaken_2 = 1;
        cyc();
        cyc();
        rst = 1;
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL rmw_outs got=%b exp=%b", outs, 6'b0); end
        cyc();
        rst = 0;
        clear();
        exp_cnt = 0;
        checks++;
        if (hz.StallCnt !== 16'd0) begin errs++; $display("FAIL rmw_cnt got=%0d exp=0", hz.StallCnt); end
        hz.MemReq_3 = 1; hz.MemReady_3 = 1;
        set_lu();
        #1;
        checks++;
        if (outs !== 6'b110001) begin errs++; $display("FAIL rmw_run got=%b exp=%b", outs, 6'b110001); end
        cyc();
        exp_cnt++;
        clear();
        #1;
        checks++;
        if (outs !== 6'b0) begin errs++; $display("FAIL rmw_nopend got=%b exp=%b", outs, 6'b0); end
    endtask

    task automatic test_timeout();
        hz.MemReq_3 = 1; hz.MemReady_3 = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if (outs !== 6'b111100) begin errs++; $display("FAIL to_stall%0d got=%b exp=%b", i, outs, 6'b111100); end
            if (i == 15) begin
                checks++;
                if (hz.MemErr !== 1'b0) begin errs++; $display("FAIL to_early got=%b exp=0", hz.MemErr); end
            end
            cyc();
            exp_cnt++;
        end
        hz.MemReady_3 = 1;
        #1;
        checks++;
        if (hz.MemErr !== 1'b1 || outs !== 6'b0) begin
            errs++; $display("FAIL to_err got err=%b outs=%b exp err=1 outs=000000", hz.MemErr, outs);
        end
        cyc();
        clear();
        cyc();
        cyc();
        checks++;
        if (hz.MemErr !== 1'b1) begin errs++; $display("FAIL to_sticky got=%b exp=1", hz.MemErr); end
        checks++;
        if (hz.StallCnt !== 16'(exp_cnt)) begin errs++; $display("FAIL to_cnt got=%0d exp=%0d", hz.StallCnt, exp_cnt); end
        rst = 1;
        cyc();
        rst = 0;
        checks++;
        if (hz.MemErr !== 1'b0) begin errs++; $display("FAIL to_rstclr got=%b exp=0", hz.MemErr); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_wait();
        test_branch_lu();
        test_reset_mwait();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
